split_eval_stream: RTL and testbench
====================================

Name: split_eval_stream

Overview:
- Parametrised sequential successor of the fixed split constraint blocks.
- Those blocks take every variable in parallel and assert a constant x.
- This block receives variable assignments serially over a valid/ready stream and accumulates a signed linear form sum(coef_i * var_i).
- Per frame it reports x under a configurable relation (TRUE/LE/GE/EQ) plus an error flag; it sits between the assignment sequencer and the BDD split/merge logic.

Parameters:
- NUM_VARS, 40, variables per frame (indices 0..NUM_VARS-1).
- VAR_W, 8, width of unsigned variable value (narrower vars zero-extended upstream).
- COEF_W, 4, width of signed per-variable coefficient.
- IDX_W, $clog2(NUM_VARS), derived; index width.
- ACC_W, VAR_W+COEF_W+$clog2(NUM_VARS)+1, derived; signed accumulator and bound width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- in_valid  in  1  assignment beat valid.
- in_ready  out  1  block accepts beat.
- in_idx  in  IDX_W  variable index.
- in_value  in  VAR_W  unsigned value.
- in_coef  in  COEF_W  signed coefficient.
- in_last  in  1  final beat of frame.
- cfg_mode  in  2  0=TRUE, 1=LE, 2=GE, 3=EQ; sampled on first beat of frame.
- cfg_bound  in  ACC_W  signed bound; sampled with cfg_mode.
- x  out  1  constraint result.
- err  out  1  frame malformed.
- x_valid  out  1  result valid.
- x_ready  in  1  consumer accepts result.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: x=0, err=0, x_valid=0, in_ready=0 for the reset cycle, then 1 in IDLE. Accumulator, seen bitmap and beat count are cleared. Reset mid-frame discards the frame and returns to IDLE.
- FSM:
  - IDLE: in_ready=1. First accepted beat latches cfg_mode/cfg_bound, clears acc/seen, processes the beat, and moves to ACCUM. If that beat has in_last=1, go to EVAL instead.
  - ACCUM: in_ready=1. Each accepted beat (in_valid&&in_ready) does acc += sign_ext(in_coef)*zero_ext(in_value) in full ACC_W precision with no saturation, sets seen[in_idx], and increments count. in_last accepted -> EVAL.
  - EVAL: in_ready=0, one cycle. Computes x/err and registers them, then -> OUT.
  - OUT: x_valid=1, in_ready=0. x/err held stable until x_ready. On x_valid&&x_ready -> IDLE; the next frame may be accepted the cycle after.
- Latency: last beat accepted at cycle t gives x_valid=1 at t+2.
- Error conditions (sticky per frame):
  - in_idx >= NUM_VARS: beat ignored for acc.
  - seen[in_idx] already set: duplicate, beat ignored for acc.
  - At EVAL, not all seen bits are set.
  - When err=1, x=0 regardless of mode.
- Result when err=0:
  - TRUE: x=1, matching the legacy constant behaviour.
  - LE: x=(acc<=bound), signed.
  - GE: x=(acc>=bound), signed.
  - EQ: x=(acc==bound).
- Boundary cases:
  - in_valid while in_ready=0: beat not consumed; upstream holds it.
  - in_idx/in_value may change freely when in_valid=0.
  - Single-beat frame with NUM_VARS>1 -> err=1.
  - x_ready asserted before x_valid has no effect.
  - cfg_* changes mid-frame are ignored.

Decomposition:
- Shared package split_pkg holds the mode enum (MODE_TRUE/LE/GE/EQ), the state enum (IDLE/ACCUM/EVAL/OUT), and width-derivation functions for ACC_W.
- One sub-module, split_mac_acc: signed multiply-accumulate with clear/enable.
- Seen bitmap, FSM and compare stay in the top.

Test Plan:
- NUM_VARS=4, mode TRUE, beats idx 0..3 all value 0, last on idx3 -> x_valid at t+2, x=1, err=0.
- NUM_VARS=4, mode LE bound=10, (idx,val,coef)=(0,3,1),(1,2,2),(2,1,-1),(3,0,7): acc=6 -> x=1. Same frame with bound=5 -> x=0.
- Mode EQ bound=-8, single var coef=-8 val=1, others coef 0 -> x=1. GE bound=-7 -> x=0.
- Duplicate idx1, missing idx2, last after 4 beats -> err=1, x=0. Next clean frame -> err=0.
- Backpressure: x_ready held 0 for 5 cycles -> x/err stable, in_ready=0, extra in_valid beats not consumed. x_ready=1 -> IDLE, held beat accepted next cycle.
- rst_n pulled low mid-frame after 2 beats -> outputs 0 asynchronously. Full frame afterwards evaluates with no residue from the aborted frame.

Source files
------------

// File: rtl/split_pkg.sv
// Shared types and width helpers for the streaming split-constraint evaluator.
package split_pkg;

    typedef enum logic [1:0] {MODE_TRUE, MODE_LE, MODE_GE, MODE_EQ} split_mode_e;
    typedef enum logic [1:0] {IDLE, ACCUM, EVAL, OUT} split_state_e;

    function automatic int idx_w_f(input int num_vars);
        return (num_vars > 1) ? $clog2(num_vars) : 1;
    endfunction

    // One extra bit on top of product + growth keeps the signed sum exact.
    function automatic int acc_w_f(input int num_vars, input int var_w, input int coef_w);
        return var_w + coef_w + $clog2(num_vars) + 1;
    endfunction

endpackage

// File: rtl/split_mac_acc.sv
// Signed multiply-accumulate: clr restarts the sum, en adds coef*value in full width.
module split_mac_acc
    import split_pkg::*;
#(
    parameter int VAR_W  = 8,
    parameter int COEF_W = 4,
    parameter int ACC_W  = 19
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [COEF_W-1:0] coef,
    input  logic        [VAR_W-1:0]  value,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [ACC_W-1:0] coef_x;
    logic signed [ACC_W-1:0] value_x;
    logic signed [ACC_W-1:0] prod;

    assign coef_x  = ACC_W'(coef);
    assign value_x = signed'({{(ACC_W-VAR_W){1'b0}}, value});
    assign prod    = coef_x * value_x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= '0;
        else        acc <= (clr ? '0 : acc) + (en ? prod : '0);
    end

endmodule

// File: rtl/split_eval_stream.sv
// Serial split-constraint evaluator: accumulates sum(coef*var) per frame and
// reports the relation against a bound, with a malformed-frame flag.
module split_eval_stream
    import split_pkg::*;
#(
    parameter  int NUM_VARS = 40,
    parameter  int VAR_W    = 8,
    parameter  int COEF_W   = 4,
    localparam int IDX_W    = idx_w_f(NUM_VARS),
    localparam int ACC_W    = acc_w_f(NUM_VARS, VAR_W, COEF_W)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic        [IDX_W-1:0]  in_idx,
    input  logic        [VAR_W-1:0]  in_value,
    input  logic signed [COEF_W-1:0] in_coef,
    input  logic                     in_last,
    input  logic        [1:0]        cfg_mode,
    input  logic signed [ACC_W-1:0]  cfg_bound,
    output logic                     x,
    output logic                     err,
    output logic                     x_valid,
    input  logic                     x_ready
);

    split_state_e            state, state_nxt;
    split_mode_e             mode_q;
    logic signed [ACC_W-1:0] bound_q;
    logic signed [ACC_W-1:0] acc;
    logic [NUM_VARS-1:0]     seen_q, seen_base, idx_hot;
    logic                    err_acc_q, err_base, err_f;
    logic                    rdy_q, beat_fire, first_beat, bad_idx, good, cmp;

    // in_ready stays low until the first clock after reset release.
    assign in_ready   = rdy_q && (state == IDLE || state == ACCUM);
    assign x_valid    = (state == OUT);
    assign beat_fire  = in_valid && in_ready;
    assign first_beat = beat_fire && (state == IDLE);

    // A new frame starts from a clean bitmap and error flag.
    assign seen_base = (state == IDLE) ? '0 : seen_q;
    assign err_base  = (state == IDLE) ? 1'b0 : err_acc_q;
    assign bad_idx   = (32'(in_idx) >= NUM_VARS);
    assign good      = !bad_idx && !seen_base[in_idx];
    assign idx_hot   = NUM_VARS'(1) << in_idx;
    assign err_f     = err_acc_q || !(&seen_q);

    split_mac_acc #(.VAR_W(VAR_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (first_beat),
        .en    (beat_fire && good),
        .coef  (in_coef),
        .value (in_value),
        .acc   (acc)
    );

    always_comb begin
        cmp = 1'b1;
        case (mode_q)
            MODE_TRUE: cmp = 1'b1;
            MODE_LE:   cmp = (acc <= bound_q);
            MODE_GE:   cmp = (acc >= bound_q);
            MODE_EQ:   cmp = (acc == bound_q);
            default:   cmp = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (beat_fire) state_nxt = in_last ? EVAL : ACCUM;
            ACCUM:   if (beat_fire && in_last) state_nxt = EVAL;
            EVAL:    state_nxt = OUT;
            OUT:     if (x_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rdy_q     <= 1'b0;
            mode_q    <= MODE_TRUE;
            bound_q   <= '0;
            seen_q    <= '0;
            err_acc_q <= 1'b0;
            x         <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy_q <= 1'b1;
            if (first_beat) begin
                mode_q  <= split_mode_e'(cfg_mode);
                bound_q <= cfg_bound;
            end
            if (beat_fire) begin
                seen_q    <= seen_base | (good ? idx_hot : '0);
                err_acc_q <= err_base | !good;
            end
            if (state == EVAL) begin
                err <= err_f;
                x   <= !err_f && cmp;
            end
        end
    end

endmodule

// File: tb/tb_split_eval_stream.sv
// Randomized bench for split_eval_stream against a frame-level reference model.
module tb_split_eval_stream;

    localparam int NV = 4;
    localparam int VW = 8;
    localparam int CW = 4;
    localparam int IW = 2;
    localparam int AW = VW + CW + 2 + 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [IW-1:0]        in_idx = '0;
    logic [VW-1:0]        in_value = '0;
    logic signed [CW-1:0] in_coef = '0;
    logic                 in_last = 1'b0;
    logic [1:0]           cfg_mode = '0;
    logic signed [AW-1:0] cfg_bound = '0;
    logic                 x, err, x_valid;
    logic                 x_ready = 1'b0;
    bit                   hold = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    split_eval_stream #(.NUM_VARS(NV), .VAR_W(VW), .COEF_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_idx(in_idx), .in_value(in_value), .in_coef(in_coef), .in_last(in_last),
        .cfg_mode(cfg_mode), .cfg_bound(cfg_bound), .x(x), .err(err),
        .x_valid(x_valid), .x_ready(x_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Consumer: random x_ready unless the stimulus holds it low.
    always @(posedge clk) begin
        #1;
        x_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // ---------------- reference model + compare ----------------
    typedef struct {int x; int err;} res_t;
    res_t exp_q[$];
    int   m_acc, m_mode, m_bound, m_err;
    bit   m_seen[NV];
    bit   m_in_frame = 0;
    int   cyc = 0, last_cyc = 0;
    bit   prev_xv = 0, prev_xr = 0;
    int   held_x, held_err;
    int   res_cnt = 0, res_x = 0, res_err = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_in_frame = 0;
            exp_q.delete();
            prev_xv = 0;
            prev_xr = 0;
            chk("rst_x_valid", int'(x_valid), 0);
            chk("rst_in_ready", int'(in_ready), 0);
        end else begin
            if (prev_xv && prev_xr) chk("ready_after_out", int'(in_ready), 1);
            if (x_valid) begin
                chk("ready_in_out", int'(in_ready), 0);
                if (prev_xv && !prev_xr) begin
                    chk("x_hold", int'(x), held_x);
                    chk("err_hold", int'(err), held_err);
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_x_valid", 1, 0);
                end else begin
                    res_t r;
                    r = exp_q.pop_front();
                    chk("x", int'(x), r.x);
                    chk("err", int'(err), r.err);
                    chk("latency", cyc - last_cyc, 2);
                    held_x = int'(x);
                    held_err = int'(err);
                    res_x = int'(x);
                    res_err = int'(err);
                    res_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                int idx;
                idx = int'(in_idx);
                if (!m_in_frame) begin
                    m_in_frame = 1;
                    m_acc = 0;
                    m_err = 0;
                    m_mode = int'(cfg_mode);
                    m_bound = int'(cfg_bound);
                    foreach (m_seen[i]) m_seen[i] = 0;
                end
                if (idx >= NV || m_seen[idx]) m_err = 1;
                else begin
                    m_seen[idx] = 1;
                    m_acc += int'(in_coef) * int'(in_value);
                end
                if (in_last) begin
                    res_t r;
                    foreach (m_seen[i]) if (!m_seen[i]) m_err = 1;
                    case (m_mode)
                        0: r.x = 1;
                        1: r.x = (m_acc <= m_bound);
                        2: r.x = (m_acc >= m_bound);
                        default: r.x = (m_acc == m_bound);
                    endcase
                    if (m_err) r.x = 0;
                    r.err = m_err;
                    exp_q.push_back(r);
                    last_cyc = cyc;
                    m_in_frame = 0;
                end
            end
            prev_xv = x_valid;
            prev_xr = x_ready;
        end
    end

    // ---------------- stimulus ----------------
    int f_n;
    int f_idx[8], f_val[8], f_coef[8];

    task automatic drive_beat(input int idx, input int val, input int coef, input bit last,
                              input int mode, input int bound);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_idx = IW'(idx);
        in_value = VW'(val);
        in_coef = CW'(coef);
        in_last = last;
        cfg_mode = 2'(mode);
        cfg_bound = AW'(bound);
        n = 0;
        acc = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("beat_timeout", 0, 1);
        in_valid = 1'b0;
        in_idx = IW'($urandom);
        in_value = VW'($urandom);
        in_last = 1'b0;
    endtask

    task automatic send_frame(input int mode, input int bound, input bit gaps);
        for (int i = 0; i < f_n; i++) begin
            if (i == 0) drive_beat(f_idx[i], f_val[i], f_coef[i], i == f_n - 1, mode, bound);
            else drive_beat(f_idx[i], f_val[i], f_coef[i], i == f_n - 1,
                            int'($urandom_range(0, 3)), int'($urandom_range(0, 4000)) - 2000);
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_result(input int start, input string nm, input int ex, input int ee);
        int n;
        n = 0;
        while (res_cnt == start && n < 100) begin @(posedge clk); n++; end
        if (res_cnt == start) chk({nm, "_timeout"}, 0, 1);
        else begin
            chk({nm, "_x"}, res_x, ex);
            chk({nm, "_err"}, res_err, ee);
        end
    endtask

    task automatic set4(input int v0, input int c0, input int v1, input int c1,
                        input int v2, input int c2, input int v3, input int c3);
        f_n = 4;
        for (int i = 0; i < 4; i++) f_idx[i] = i;
        f_val[0] = v0; f_coef[0] = c0; f_val[1] = v1; f_coef[1] = c1;
        f_val[2] = v2; f_coef[2] = c2; f_val[3] = v3; f_coef[3] = c3;
    endtask

    task automatic lit_frame(input string nm, input int mode, input int bound,
                             input int ex, input int ee);
        int s;
        s = res_cnt;
        send_frame(mode, bound, 1'b0);
        wait_result(s, nm, ex, ee);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_x", int'(x), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_x_valid", int'(x_valid), 0);
        chk("reset_in_ready", int'(in_ready), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        set4(0, 0, 0, 0, 0, 0, 0, 0);
        lit_frame("true_zero", 0, 0, 1, 0);
        set4(3, 1, 2, 2, 1, -1, 0, 7);
        lit_frame("le_10", 1, 10, 1, 0);
        lit_frame("le_5", 1, 5, 0, 0);
        set4(1, -8, 55, 0, 200, 0, 255, 0);
        lit_frame("eq_m8", 3, -8, 1, 0);
        lit_frame("ge_m7", 2, -7, 0, 0);

        set4(1, 1, 2, 1, 3, 1, 4, 1);
        f_idx[2] = 1;
        lit_frame("dup_missing", 0, 0, 0, 1);
        set4(1, 1, 2, 1, 3, 1, 4, 1);
        lit_frame("clean_after_err", 0, 0, 1, 0);
        f_n = 1;
        lit_frame("single_beat", 0, 0, 0, 1);

        // Backpressure: result held while the next frame's first beat waits.
        hold = 1'b1;
        set4(9, 2, 8, 3, 7, 4, 6, 5);
        s = res_cnt;
        send_frame(2, 100, 1'b0);
        fork
            begin repeat (8) @(posedge clk); hold = 1'b0; end
        join_none
        send_frame(0, 0, 1'b0);
        wait_result(s, "bp_first", 1, 0);
        wait_result(s + 1, "bp_second", 1, 0);

        // Mid-frame reset while x still shows the previous frame's 1.
        repeat (4) @(posedge clk); #1;
        set4(3, 1, 2, 2, 1, -1, 0, 7);
        f_n = 2;
        send_frame(1, 0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_x", int'(x), 0);
        chk("midrst_err", int'(err), 0);
        chk("midrst_x_valid", int'(x_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        set4(3, 1, 2, 2, 1, -1, 0, 7);
        lit_frame("after_rst_le6", 1, 6, 1, 0);

        // Randomized frames.
        for (int k = 0; k < 150; k++) begin
            int sum, bnd;
            if ($urandom_range(0, 3) != 0) begin
                f_n = 4;
                for (int i = 0; i < 4; i++) f_idx[i] = i;
                for (int i = 3; i > 0; i--) begin
                    int j, t;
                    j = int'($urandom_range(0, i));
                    t = f_idx[i]; f_idx[i] = f_idx[j]; f_idx[j] = t;
                end
            end else begin
                f_n = int'($urandom_range(1, 6));
                for (int i = 0; i < f_n; i++) f_idx[i] = int'($urandom_range(0, 3));
            end
            sum = 0;
            for (int i = 0; i < f_n; i++) begin
                f_val[i] = int'($urandom_range(0, 255));
                f_coef[i] = int'($urandom_range(0, 15)) - 8;
                sum += f_val[i] * f_coef[i];
            end
            bnd = ($urandom_range(0, 2) == 0) ? sum + int'($urandom_range(0, 2)) - 1
                                              : int'($urandom_range(0, 8000)) - 4000;
            send_frame(int'($urandom_range(0, 3)), bnd, 1'b1);
        end
        repeat (30) @(posedge clk);
        chk("results_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
